// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr family: mode encoding and
// round-robin pointer arithmetic.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Wrap-around increment of a channel index within 0..n-1.
  function automatic int next_ptr(input int g, input int n);
    if (g >= n - 32'sd1) begin
      return 32'sd0;
    end else begin
      return g + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: rotating-priority grant starting at an internal
// pointer; on adv the pointer moves just past the channel that transferred.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              adv,
  output logic [N_CH-1:0]   gnt,
  output logic [SEL_W-1:0]  gnt_idx
);

  logic [SEL_W-1:0] rr_ptr_r;
  logic             found_s;
  int               cand_s;

  // first requester at or after rr_ptr_r, wrapping past N_CH-1 to 0
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found_s = 1'b0;
    cand_s  = 32'sd0;
    for (int k = 0; k < N_CH; k++) begin
      cand_s = int'(rr_ptr_r) + k;
      if (cand_s >= N_CH) begin
        cand_s = cand_s - N_CH;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req[cand_s]) begin
        found_s        = 1'b1;
        gnt[cand_s]    = 1'b1;
        gnt_idx        = SEL_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer register; ptr names the channel that just transferred
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (adv) begin
      rr_ptr_r <= SEL_W'(next_ptr(int'(ptr), N_CH));
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH-to-1 valid/ready stream mux with external-select or round-robin
// arbitration feeding a single-entry registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*WIDTH-1:0]  in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [N_CH-1:0]  rr_gnt_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic [N_CH-1:0]  sel_gnt_s;
  logic [N_CH-1:0]  grant_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             ld_en_s;
  logic             xfer_s;
  logic             adv_s;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_ch_r;
  logic             out_valid_r;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .ptr     (rr_idx_s),
    .adv     (adv_s),
    .gnt     (rr_gnt_s),
    .gnt_idx (rr_idx_s)
  );

  // external select; indices beyond N_CH (non power-of-2 N_CH) never grant
  always_comb begin
    sel_gnt_s = '0;
    if (int'(sel) < N_CH) begin
      sel_gnt_s[sel] = in_valid[sel];
    end else begin
      sel_gnt_s = '0;
    end
  end

  // mode mux, load enable and handshake
  always_comb begin
    grant_s     = '0;
    grant_idx_s = '0;
    in_ready    = '0;
    if (mode == MODE_RR) begin
      grant_s     = rr_gnt_s;
      grant_idx_s = rr_idx_s;
    end else begin
      grant_s     = sel_gnt_s;
      grant_idx_s = sel;
    end
    ld_en_s = ~out_valid_r | out_ready;
    if (rst) begin
      in_ready = '0;
    end else begin
      in_ready = grant_s & {N_CH{ld_en_s}};
    end
    xfer_s = |in_ready;
    adv_s  = xfer_s & (mode == MODE_RR);
  end

  // output register: load on transfer, clear valid on drain, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_data_r  <= in_data[int'(grant_idx_s)*WIDTH +: WIDTH];
      out_ch_r    <= grant_idx_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized
// traffic against a behavioural reference model.
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready = 1'b0;

  logic [23:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [1:0]  sel3 = '0;
  logic [7:0]  out_data3;
  logic [1:0]  out_ch3;
  logic        out_valid3;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch;
  int       m_ptr;

  stream_mux_rr #(.WIDTH(8), .N_CH(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .N_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .mode(1'b0), .sel(sel3), .out_data(out_data3),
    .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(1'b1)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_ptr   = 0;
  endfunction

  function automatic int model_grant();
    if (mode) begin
      for (int k = 0; k < 4; k++) begin
        int c = (m_ptr + k) % 4;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (in_valid[sel]) return int'(sel);
    return -1;
  endfunction

  // one clock of model-checked operation; inputs must already be driven
  task automatic step();
    int       g;
    bit       ld;
    bit [3:0] exp_rdy;
    #1;
    ld      = !m_valid || out_ready;
    g       = model_grant();
    exp_rdy = 4'b0000;
    if (g >= 0 && ld) exp_rdy[g] = 1'b1;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL model_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_rdy);
    end
    checks++;
    if (out_valid !== m_valid) begin
      errors++;
      $display("FAIL model_out_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
    end
    checks++;
    if (out_data !== m_data || out_ch !== 2'(m_ch)) begin
      errors++;
      $display("FAIL model_out_beat t=%0t got=%h/%0d exp=%h/%0d", $time, out_data, out_ch, m_data, m_ch);
    end
    @(posedge clk);
    if (g >= 0 && ld) begin
      m_data  = in_data[g*8 +: 8];
      m_ch    = g;
      m_valid = 1'b1;
      if (mode) m_ptr = (g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    in_valid  = 4'b1111;
    mode      = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hA3A2A1A0;
    rst       = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_ch !== 2'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b ch=%0d d=%h exp v=0 rdy=0000 ch=0 d=00",
               out_valid, in_ready, out_ch, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_rr got=%b exp=0001", in_ready);
    end
    step();
  endtask

  task automatic test_rr_all();
    do_reset();
    mode      = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'hA3A2A1A0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'(k % 4) || out_data !== 8'hA0 + 8'(k % 4)) begin
        errors++;
        $display("FAIL rr_all beat%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h",
                 k, out_valid, out_ch, out_data, k % 4, 8'hA0 + 8'(k % 4));
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_seq [4] = '{3, 1, 3, 1};
    do_reset();
    mode      = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'h44332211;
    in_valid  = 4'b0010;
    step();
    in_valid  = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_ch !== 2'(exp_seq[k])) begin
        errors++;
        $display("FAIL rr_sparse beat%0d got ch=%0d exp ch=%0d", k, out_ch, exp_seq[k]);
      end
    end
  endtask

  task automatic test_sel_stall();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd2;
    in_valid  = 4'b0100;
    in_data   = 32'h115C2233;
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        mode = 1'b1;
        sel  = 2'd0;
      end
      step();
      checks++;
      if (out_data !== 8'h5C || out_valid !== 1'b1 || in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL sel_stall cyc%0d got d=%h v=%b rdy=%b exp d=5c v=1 rdy=0000",
                 k, out_data, out_valid, in_ready);
      end
    end
    mode      = 1'b0;
    sel       = 2'd2;
    in_data   = 32'h115D2233;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL sel_release_ready got=%b exp=0100", in_ready);
    end
    step();
    checks++;
    if (out_data !== 8'h5D || out_valid !== 1'b1 || out_ch !== 2'd2) begin
      errors++;
      $display("FAIL sel_release_load got d=%h v=%b ch=%0d exp d=5d v=1 ch=2", out_data, out_valid, out_ch);
    end
  endtask

  task automatic test_sel_invalid();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    in_data   = 32'h00000077;
    out_ready = 1'b1;
    step();
    sel      = 2'd1;
    in_valid = 4'b1101;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h77) begin
      errors++;
      $display("FAIL sel_invalid_drain got v=%b d=%h exp v=0 d=77", out_valid, out_data);
    end
    in_valid3 = 3'b111;
    in_data3  = 24'hC3B2A1;
    sel3      = 2'd3;
    #1;
    checks++;
    if (in_ready3 !== 3'b000) begin
      errors++;
      $display("FAIL n3_sel_oob_ready got=%b exp=000", in_ready3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid3 !== 1'b0) begin
      errors++;
      $display("FAIL n3_sel_oob_valid got=%b exp=0", out_valid3);
    end
    sel3 = 2'd2;
    #1;
    checks++;
    if (in_ready3 !== 3'b100) begin
      errors++;
      $display("FAIL n3_sel2_ready got=%b exp=100", in_ready3);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 8'hC3) begin
      errors++;
      $display("FAIL n3_sel2_beat got v=%b ch=%0d d=%h exp v=1 ch=2 d=c3", out_valid3, out_ch3, out_data3);
    end
    in_valid3 = 3'b000;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = 4'b0001;
    in_data   = 32'h000000E1;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_stall_reset got v=%b rdy=%b d=%h exp v=0 rdy=0000 d=00", out_valid, in_ready, out_data);
    end
    in_valid = 4'b0000;
    #3;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stall_no_beat cyc%0d got v=%b exp v=0", k, out_valid);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_all();
    test_rr_sparse();
    test_sel_stall();
    test_sel_invalid();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
